// File: rtl/fft8_pkg.sv
// fft8_pkg: shared sizes, sequencer state encoding and bin-order helper for the 8-point FFT sequencer
package fft8_pkg;
  localparam int FFT_N = 8;
  localparam int FFT_LOG2N = 3;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  function automatic logic [FFT_LOG2N-1:0] bitrev3(input logic [FFT_LOG2N-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction
endpackage

// File: rtl/fft8_frame_sequencer_if.sv
// fft8_frame_sequencer_if: input stream, core bus and output stream of the FFT sequencer
//   s_*      : valid/ready sample input stream
//   fft_*    : write/start strobes and packed x0..x7 / X0..X7 buses to/from the core
//   m_*      : valid/ready output stream with bin index and frame-last flag
//   busy     : sequencer not idle
//   master   : environment side, slave : sequencer side
interface fft8_frame_sequencer_if #(parameter int W = 16);
  import fft8_pkg::*;
  logic                 s_valid, s_ready;
  logic [W-1:0]         s_real, s_imag;
  logic                 fft_write, fft_start;
  logic [FFT_N*W-1:0]   fft_in_real, fft_in_imag, fft_out_real, fft_out_imag;
  logic                 m_valid, m_ready;
  logic [W-1:0]         m_real, m_imag;
  logic [FFT_LOG2N-1:0] m_index;
  logic                 m_last, busy;
  modport master (
    output s_valid, s_real, s_imag, fft_out_real, fft_out_imag, m_ready,
    input  s_ready, fft_write, fft_start, fft_in_real, fft_in_imag,
           m_valid, m_real, m_imag, m_index, m_last, busy
  );
  modport slave (
    input  s_valid, s_real, s_imag, fft_out_real, fft_out_imag, m_ready,
    output s_ready, fft_write, fft_start, fft_in_real, fft_in_imag,
           m_valid, m_real, m_imag, m_index, m_last, busy
  );
endinterface

// File: rtl/fft8_in_buffer.sv
// fft8_in_buffer: 8-entry input frame register file filled from a valid/ready stream
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_valid, o_ready   : sample handshake (o_ready = !in_full)
//   i_real, i_imag     : sample data
//   i_clear            : frame consumed, clears in_full at the end of this cycle
//   o_full_nxt         : in_full as it will be after this edge (frame complete now or earlier)
//   o_real, o_imag     : packed x0..x7, x0 in the low word
module fft8_in_buffer import fft8_pkg::*; #(
  parameter int W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [W-1:0]       i_real,
  input  logic [W-1:0]       i_imag,
  input  logic               i_clear,
  output logic               o_ready,
  output logic               o_full_nxt,
  output logic [FFT_N*W-1:0] o_real,
  output logic [FFT_N*W-1:0] o_imag
);
  logic [FFT_LOG2N-1:0] r_wr_ptr;
  logic                 r_full;
  logic [W-1:0]         r_re [FFT_N];
  logic [W-1:0]         r_im [FFT_N];
  logic                 w_hs;
  assign w_hs = i_valid && !r_full;
  assign o_ready = !r_full;
  assign o_full_nxt = r_full || (w_hs && r_wr_ptr == FFT_LOG2N'(FFT_N - 1));
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_hs) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_full <= o_full_nxt && !i_clear;
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_hs) begin
      r_re[r_wr_ptr] <= i_real;
      r_im[r_wr_ptr] <= i_imag;
    end
  end
  for (genvar g = 0; g < FFT_N; g++) begin : g_pack
    assign o_real[g*W +: W] = r_re[g];
    assign o_imag[g*W +: W] = r_im[g];
  end
endmodule

// File: rtl/fft8_frame_sequencer.sv
// fft8_frame_sequencer: frames a sample stream into the 8-point FFT core and streams the bins back out
//   CLK, RST : clock, synchronous active-high reset
//   bus      : fft8_frame_sequencer_if.slave (s_* input stream, fft_* core bus, m_* output stream, busy)
//   W, START_CYCLES : sample width, cycles fft_start is held
//   FFT_BITREV_OUT_EN : when defined, bins are emitted in bit-reversed order (m_index stays the true bin)
module fft8_frame_sequencer import fft8_pkg::*; #(
  parameter int W = 16,
  parameter int START_CYCLES = 2
) (
  input logic CLK,
  input logic RST,
  fft8_frame_sequencer_if.slave bus
);
  localparam int CW = START_CYCLES > 1 ? $clog2(START_CYCLES) : 1;
  state_t               r_state, w_next;
  logic [CW-1:0]        r_run_cnt;
  logic [FFT_LOG2N-1:0] r_rd_ptr, w_bin;
  logic                 w_full_nxt, w_write, w_start, w_m_hs;
  fft8_in_buffer #(.W(W)) u_buf (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_valid    (bus.s_valid),
    .i_real     (bus.s_real),
    .i_imag     (bus.s_imag),
    .i_clear    (w_write),
    .o_ready    (bus.s_ready),
    .o_full_nxt (w_full_nxt),
    .o_real     (bus.fft_in_real),
    .o_imag     (bus.fft_in_imag)
  );
`ifdef FFT_BITREV_OUT_EN
  assign w_bin = bitrev3(r_rd_ptr);
`else
  assign w_bin = r_rd_ptr;
`endif
  assign w_m_hs = bus.m_valid && bus.m_ready;
  // the completing input handshake is looked at directly so LOAD follows it without a dead cycle
  always_comb begin
    w_next = r_state;
    w_write = 1'b0;
    w_start = 1'b0;
    case (r_state)
      IDLE:  w_next = w_full_nxt ? LOAD : IDLE;
      LOAD: begin
        w_write = 1'b1;
        w_next = RUN;
      end
      RUN: begin
        w_start = 1'b1;
        w_next = r_run_cnt == CW'(START_CYCLES - 1) ? DRAIN : RUN;
      end
      DRAIN: w_next = (w_m_hs && r_rd_ptr == 3'd7) ? (w_full_nxt ? LOAD : IDLE) : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_run_cnt <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_next;
      r_run_cnt <= r_state == RUN ? r_run_cnt + 1'b1 : '0;
      r_rd_ptr <= r_state != DRAIN ? '0 : w_m_hs ? r_rd_ptr + 1'b1 : r_rd_ptr;
    end
  end
  assign bus.fft_write = w_write;
  assign bus.fft_start = w_start;
  assign bus.m_valid = r_state == DRAIN;
  assign bus.m_real = bus.fft_out_real[int'(w_bin)*W +: W];
  assign bus.m_imag = bus.fft_out_imag[int'(w_bin)*W +: W];
  assign bus.m_index = w_bin;
  assign bus.m_last = r_state == DRAIN && r_rd_ptr == 3'd7;
  assign bus.busy = r_state != IDLE;
endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// tb_fft8_frame_sequencer: randomized self-checking bench with a behavioural core and DFT reference
module tb_fft8_frame_sequencer;
  localparam int W = 16;
  localparam int SC = 2;
  logic CLK = 1'b0;
  logic RST;
  fft8_frame_sequencer_if #(.W(W)) bus ();
  fft8_frame_sequencer #(.W(W), .START_CYCLES(SC)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
  always #5 CLK = ~CLK;
  int n_cmp = 0, n_bad = 0, to_cnt = 0, both_hi = 0, hold_bad = 0, n_got = 0;
  int cyc = 0, hs_cyc = 0;
  int wr_q[$], st_q[$];
  logic [W-1:0] obs_re[16], obs_im[16], exp_re[16], exp_im[16];
  logic [2:0] obs_idx[16], exp_idx[16];
  logic obs_last[16], exp_last[16];
  int obs_cyc[16];
  always @(posedge CLK) cyc++;
  function automatic void dft(input int xr[8], input int xi[8], input int k, output logic [W-1:0] yr, output logic [W-1:0] yi);
    real ar, ai, th;
    ar = 0.0;
    ai = 0.0;
    for (int n = 0; n < 8; n++) begin
      th = 2.0 * 3.14159265358979 * k * n / 8.0;
      ar += xr[n] * $cos(th) + xi[n] * $sin(th);
      ai += xi[n] * $cos(th) - xr[n] * $sin(th);
    end
    yr = W'($rtoi(ar + (ar >= 0.0 ? 0.5 : -0.5)));
    yi = W'($rtoi(ai + (ai >= 0.0 ? 0.5 : -0.5)));
  endfunction
  logic c_rst, c_wr, c_st;
  logic [8*W-1:0] c_inr, c_ini, core_re, core_im;
  int lat_r[8], lat_i[8], sc;
  assign bus.fft_out_real = core_re;
  assign bus.fft_out_imag = core_im;
  always @(negedge CLK) begin
    c_rst = RST;
    c_wr = bus.fft_write;
    c_st = bus.fft_start;
    c_inr = bus.fft_in_real;
    c_ini = bus.fft_in_imag;
    if (bus.fft_write) wr_q.push_back(cyc);
    if (bus.fft_start) st_q.push_back(cyc);
    if (bus.fft_write && bus.fft_start) both_hi++;
  end
  always @(posedge CLK) begin : core_model
    logic [W-1:0] yr, yi;
    if (c_rst) sc = 0;
    else begin
      if (c_wr) begin
        for (int k = 0; k < 8; k++) begin
          lat_r[k] = $signed(c_inr[k*W +: W]);
          lat_i[k] = $signed(c_ini[k*W +: W]);
        end
        sc = 0;
      end
      if (c_st) begin
        sc++;
        if (sc == SC)
          for (int k = 0; k < 8; k++) begin
            dft(lat_r, lat_i, k, yr, yi);
            core_re[k*W +: W] <= yr;
            core_im[k*W +: W] <= yi;
          end
      end
    end
  end
  task automatic build_exp(input int fr, input int xr[8], input int xi[8]);
    logic [2:0] jj, b;
    for (int j = 0; j < 8; j++) begin
      jj = 3'(j);
`ifdef FFT_BITREV_OUT_EN
      b = {jj[0], jj[1], jj[2]};
`else
      b = jj;
`endif
      dft(xr, xi, int'(b), exp_re[fr*8+j], exp_im[fr*8+j]);
      exp_idx[fr*8+j] = b;
      exp_last[fr*8+j] = j == 7;
    end
  endtask
  task automatic rand_frame(output int xr[8], output int xi[8]);
    for (int k = 0; k < 8; k++) begin
      xr[k] = int'($urandom_range(0, 2000)) - 1000;
      xi[k] = int'($urandom_range(0, 2000)) - 1000;
    end
  endtask
  task automatic drive_sample(input int re, input int im);
    int w = 0;
    bus.s_valid = 1'b1;
    bus.s_real = W'(re);
    bus.s_imag = W'(im);
    @(negedge CLK);
    while (!bus.s_ready && w < 300) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      w++;
    end
    if (!bus.s_ready) to_cnt++;
    else hs_cyc = cyc;
    @(posedge CLK); #1;
  endtask
  task automatic send_frame(input int xr[8], input int xi[8], input bit gaps);
    for (int k = 0; k < 8; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bus.s_valid = 1'b0;
        @(posedge CLK); #1;
      end
      drive_sample(xr[k], xi[k]);
    end
    bus.s_valid = 1'b0;
  endtask
  task automatic collect(input int n, input int mode);
    int idle_c = 0, tot = 0;
    bit held = 0, tog = 0;
    logic [2*W+3:0] prev = '0, cur;
    n_got = 0;
    hold_bad = 0;
    while (n_got < n && idle_c < 200 && tot < 2000) begin
      bus.m_ready = mode == 1 ? 1'b1 : mode == 2 ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      @(negedge CLK);
      cur = {bus.m_real, bus.m_imag, bus.m_index, bus.m_last};
      if (bus.m_valid) begin
        if (held && cur !== prev) hold_bad++;
        prev = cur;
        held = !bus.m_ready;
        idle_c = 0;
        if (bus.m_ready) begin
          obs_re[n_got] = bus.m_real;
          obs_im[n_got] = bus.m_imag;
          obs_idx[n_got] = bus.m_index;
          obs_last[n_got] = bus.m_last;
          obs_cyc[n_got] = cyc;
          n_got++;
        end
      end else begin
        if (held) hold_bad++;
        held = 0;
        idle_c++;
      end
      tot++;
      @(posedge CLK); #1;
    end
    bus.m_ready = 1'b0;
    if (n_got < n) to_cnt++;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({bus.s_ready, bus.fft_write, bus.fft_start, bus.m_valid, bus.m_last, bus.busy, bus.m_index} !== 9'b1_00000_000) begin
      n_bad++;
      $display("FAIL reset_hold got %b want 100000000", {bus.s_ready, bus.fft_write, bus.fft_start, bus.m_valid, bus.m_last, bus.busy, bus.m_index});
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({bus.s_ready, bus.fft_write, bus.fft_start, bus.m_valid, bus.busy} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_release got %b want 10000", {bus.s_ready, bus.fft_write, bus.fft_start, bus.m_valid, bus.busy});
    end
    @(posedge CLK); #1;
  endtask
  task automatic test_ramp_latency;
    int xr[8], xi[8], c;
    for (int k = 0; k < 8; k++) begin
      xr[k] = k + 1;
      xi[k] = 0;
    end
    build_exp(0, xr, xi);
    wr_q.delete();
    st_q.delete();
    fork
      send_frame(xr, xi, 1'b0);
      collect(8, 1);
    join
    c = hs_cyc;
    n_cmp++;
    if (wr_q.size() != 1 || wr_q[0] != c + 1) begin
      n_bad++;
      $display("FAIL ramp_write_cycle got n=%0d first=%0d want n=1 at %0d", wr_q.size(), wr_q.size() ? wr_q[0] : -1, c + 1);
    end
    n_cmp++;
    if (st_q.size() != SC || st_q[0] != c + 2 || st_q[SC-1] != c + 1 + SC) begin
      n_bad++;
      $display("FAIL ramp_start_cycles got n=%0d want %0d cycles from %0d", st_q.size(), SC, c + 2);
    end
    n_cmp++;
    if (n_got != 8 || obs_cyc[0] != c + 2 + SC) begin
      n_bad++;
      $display("FAIL ramp_first_valid got n=%0d cyc=%0d want 8 at %0d", n_got, obs_cyc[0], c + 2 + SC);
    end
    n_cmp++;
    if (obs_re[0] !== 16'd36 || obs_im[0] !== 16'd0) begin
      n_bad++;
      $display("FAIL ramp_x0 got (%0d,%0d) want (36,0)", $signed(obs_re[0]), $signed(obs_im[0]));
    end
    for (int j = 0; j < 8; j++) begin
      n_cmp++;
      if ({obs_re[j], obs_im[j], obs_idx[j], obs_last[j]} !== {exp_re[j], exp_im[j], exp_idx[j], exp_last[j]}) begin
        n_bad++;
        $display("FAIL ramp_out%0d got (%0d,%0d) idx=%0d last=%0d want (%0d,%0d) idx=%0d last=%0d", j, $signed(obs_re[j]), $signed(obs_im[j]), obs_idx[j], obs_last[j], $signed(exp_re[j]), $signed(exp_im[j]), exp_idx[j], exp_last[j]);
      end
    end
  endtask
  task automatic test_impulse;
    int xr[8], xi[8], lasts;
    for (int k = 0; k < 8; k++) begin
      xr[k] = k == 0 ? 256 : 0;
      xi[k] = 0;
    end
    build_exp(0, xr, xi);
    fork
      send_frame(xr, xi, 1'b1);
      collect(8, 1);
    join
    lasts = 0;
    for (int j = 0; j < 8; j++) begin
      lasts += int'(obs_last[j]);
      n_cmp++;
      if ({obs_re[j], obs_im[j], obs_idx[j], obs_last[j]} !== {16'd256, 16'd0, exp_idx[j], exp_last[j]}) begin
        n_bad++;
        $display("FAIL impulse_out%0d got (%0d,%0d) idx=%0d last=%0d want (256,0) idx=%0d last=%0d", j, $signed(obs_re[j]), $signed(obs_im[j]), obs_idx[j], obs_last[j], exp_idx[j], exp_last[j]);
      end
    end
    n_cmp++;
    if (lasts != 1 || n_got != 8) begin
      n_bad++;
      $display("FAIL impulse_last_count got lasts=%0d n=%0d want 1 and 8", lasts, n_got);
    end
  endtask
  task automatic test_back_to_back;
    int ar[8], ai[8], br[8], bi[8];
    rand_frame(ar, ai);
    rand_frame(br, bi);
    build_exp(0, ar, ai);
    build_exp(1, br, bi);
    wr_q.delete();
    fork
      begin
        send_frame(ar, ai, 1'b0);
        send_frame(br, bi, 1'b0);
      end
      collect(16, 1);
    join
    n_cmp++;
    if (n_got != 16 || wr_q.size() != 2 || wr_q[1] != obs_cyc[7] + 1) begin
      n_bad++;
      $display("FAIL b2b_load_after_last got n=%0d loads=%0d load2=%0d want 16,2,%0d", n_got, wr_q.size(), wr_q.size() > 1 ? wr_q[1] : -1, obs_cyc[7] + 1);
    end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if ({obs_re[j], obs_im[j], obs_idx[j], obs_last[j]} !== {exp_re[j], exp_im[j], exp_idx[j], exp_last[j]}) begin
        n_bad++;
        $display("FAIL b2b_out%0d got (%0d,%0d) idx=%0d last=%0d want (%0d,%0d) idx=%0d last=%0d", j, $signed(obs_re[j]), $signed(obs_im[j]), obs_idx[j], obs_last[j], $signed(exp_re[j]), $signed(exp_im[j]), exp_idx[j], exp_last[j]);
      end
    end
  endtask
  task automatic test_backpressure;
    int xr[8], xi[8];
    for (int mode = 2; mode <= 3; mode++) begin
      rand_frame(xr, xi);
      build_exp(0, xr, xi);
      fork
        send_frame(xr, xi, 1'b1);
        collect(8, mode);
      join
      for (int j = 0; j < 8; j++) begin
        n_cmp++;
        if ({obs_re[j], obs_im[j], obs_idx[j], obs_last[j]} !== {exp_re[j], exp_im[j], exp_idx[j], exp_last[j]}) begin
          n_bad++;
          $display("FAIL bp%0d_out%0d got (%0d,%0d) idx=%0d last=%0d want (%0d,%0d) idx=%0d last=%0d", mode, j, $signed(obs_re[j]), $signed(obs_im[j]), obs_idx[j], obs_last[j], $signed(exp_re[j]), $signed(exp_im[j]), exp_idx[j], exp_last[j]);
        end
      end
      @(negedge CLK);
      n_cmp++;
      if (hold_bad != 0 || n_got != 8 || bus.m_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL bp%0d_hold got changes=%0d n=%0d valid_after=%b want 0,8,0", mode, hold_bad, n_got, bus.m_valid);
      end
      @(posedge CLK); #1;
    end
  endtask
  task automatic test_reset_mid;
    int xr[8], xi[8];
    for (int k = 0; k < 5; k++) drive_sample(int'($urandom_range(0, 2000)) - 1000, 777);
    bus.s_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({bus.s_ready, bus.busy, bus.m_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL midreset_state got %b want 100", {bus.s_ready, bus.busy, bus.m_valid});
    end
    @(posedge CLK); #1;
    rand_frame(xr, xi);
    build_exp(0, xr, xi);
    fork
      send_frame(xr, xi, 1'b1);
      collect(8, 3);
    join
    for (int j = 0; j < 8; j++) begin
      n_cmp++;
      if ({obs_re[j], obs_im[j], obs_idx[j], obs_last[j]} !== {exp_re[j], exp_im[j], exp_idx[j], exp_last[j]}) begin
        n_bad++;
        $display("FAIL midreset_out%0d got (%0d,%0d) idx=%0d last=%0d want (%0d,%0d) idx=%0d last=%0d", j, $signed(obs_re[j]), $signed(obs_im[j]), obs_idx[j], obs_last[j], $signed(exp_re[j]), $signed(exp_im[j]), exp_idx[j], exp_last[j]);
      end
    end
  endtask
  task automatic test_final;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (both_hi != 0 || to_cnt != 0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL final got write_and_start=%0d timeouts=%0d busy=%b want 0,0,0", both_hi, to_cnt, bus.busy);
    end
  endtask
  initial begin
    RST = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_real = '0;
    bus.s_imag = '0;
    bus.m_ready = 1'b0;
    test_reset;
    test_ramp_latency;
    test_impulse;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_final;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/fft8_frame_sequencer.md
Name: fft8_frame_sequencer

Overview:
- Streaming front/back end and sequencer for the 8-point FFT core (eight_point_fft).
- Collects 8 complex samples from a valid/ready input stream into an input frame buffer, pulses the core's write, then holds start for START_CYCLES cycles.
- Streams the 8 results out one per handshake.
- The next frame can fill while the current frame is computing or draining.

Parameters:
- W, 16, sample word width (real and imag each); must match the core.
- START_CYCLES, 2, cycles fft_start is held high. The core needs 1 edge to load its b registers and 1 edge to register its outputs.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid&&s_ready
- s_real  in  W  input real
- s_imag  in  W  input imag
- fft_write  out  1  to core write
- fft_start  out  1  to core start
- fft_in_real  out  8*W  packed x0..x7 real, x0 in [W-1:0]
- fft_in_imag  out  8*W  packed x0..x7 imag
- fft_out_real  in  8*W  packed X0..X7 real from core
- fft_out_imag  in  8*W  packed X0..X7 imag from core
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accept
- m_real  out  W  output real
- m_imag  out  W  output imag
- m_index  out  3  bin index of current output
- m_last  out  1  high with the 8th output of a frame
- busy  out  1  sequencer not in IDLE

Behaviour:
- Fill side:
  - wr_ptr[2:0] and in_full flag.
  - s_ready = !in_full.
  - Each handshake writes buf[wr_ptr] and increments wr_ptr.
  - The handshake at wr_ptr==7 sets in_full and wraps wr_ptr to 0.
  - in_full clears at the end of the LOAD cycle; fill resumes the next cycle.
- fft_in_real/imag are driven continuously from buf.
- Sequencer FSM: IDLE, LOAD, RUN, DRAIN.
  - IDLE: if in_full, go to LOAD.
  - LOAD: fft_write=1 for exactly 1 cycle, then go to RUN with run_cnt=0.
  - RUN: fft_start=1; run_cnt increments; after START_CYCLES cycles go to DRAIN with rd_ptr=0.
  - DRAIN:
    - m_valid=1; m_real/m_imag = fft_out_*[rd_ptr]; m_index = rd_ptr; m_last = (rd_ptr==7).
    - On handshake rd_ptr increments.
    - Handshake with m_last goes to LOAD if in_full, else IDLE (back-to-back frames, no idle cycle).
- fft_write and fft_start are never high in the same cycle. Both are low outside LOAD/RUN, so the core outputs stay stable during DRAIN.
- Latency: with 8th input handshake in cycle C:
  - fft_write high in C+1
  - fft_start high C+2..C+1+START_CYCLES
  - first m_valid in C+2+START_CYCLES (C+4 at default)
- Fill and drain may overlap. A new input handshake in the same cycle as the LOAD transition is impossible because s_ready is low while in_full.
- m_ready low holds m_valid, m_real, m_imag, m_index and m_last stable.
- The core's ready output is not used; timing is by count.
- Reset:
  - State=IDLE; wr_ptr, rd_ptr, run_cnt = 0; in_full=0.
  - Outputs: s_ready=1 (combinational from in_full=0); fft_write, fft_start, m_valid, m_last, busy = 0; m_index=0.
  - buf contents are not reset.
  - Reset mid-frame discards the partial input and any undrained output.

Optional Feature:
- FFT_BITREV_OUT_EN
  - Defined: DRAIN emits bins in bit-reversed order (0,4,2,6,1,5,3,7). m_index carries the true bin number; m_last flags the 8th emitted sample (bin 7).
  - Undefined: natural order 0..7.

Decomposition:
- Shared package fft8_pkg:
  - FFT_N=8, FFT_LOG2N=3
  - state enum {IDLE, LOAD, RUN, DRAIN}
  - bitrev3 function
- Sub-module fft8_in_buffer: wr_ptr, in_full, 8-entry register file, packed outputs.
- The FSM and drain mux stay in the top module.

Test Plan:
- Reset, then 8 samples x_k=(k+1,0) with m_ready=1:
  - fft_write in C+1; fft_start in C+2,C+3; m_valid in C+4.
  - With a core model, X0 real=36.
- Impulse x0=(256,0), others 0 -> all 8 outputs (256,0), m_index 0..7, m_last only on the 8th.
- Two frames back-to-back with s_valid held high:
  - Second frame fills during RUN/DRAIN.
  - LOAD follows the first frame's m_last handshake with no IDLE cycle.
  - Outputs of frame 1 are unaffected by frame 2.
- m_ready toggled 1/0 during DRAIN -> each output held stable while m_ready=0; exactly 8 handshakes per frame.
- RST asserted after 5 input samples -> s_ready=1, wr_ptr=0; the next 8 samples form a fresh frame and the stale 5 never appear.
- FFT_BITREV_OUT_EN defined -> m_index sequence 0,4,2,6,1,5,3,7 with matching data; m_last on bin 7.
